// File: rtl/fir_prog_pkg.sv
// Shared helpers for the programmable parallel FIR: width derivation and
// the round-half-up right shift used by the output stage.
package fir_prog_pkg;

  function automatic int full_width(input int nb_in, input int nb_coef, input int n_coeffs);
    return nb_in + nb_coef + $clog2(n_coeffs);
  endfunction

  function automatic int shift_width(input int nb_full);
    return $clog2(nb_full);
  endfunction

  // Arithmetic right shift with round half toward +inf; 64 bits leaves
  // headroom for the bias add on any realistic accumulator width.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] sum,
                                                       input logic [31:0] shift);
    logic signed [63:0] bias;
    bias = 64'sd0;
    if (shift == 32'd0) return sum;
    bias = 64'sd1 <<< (shift - 32'd1);
    return (sum + bias) >>> shift;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Per-lane output stage: shift/round the full-precision sum, then clip to
// the signed NB_OUT range and flag when clipping happened.
module fir_round_sat import fir_prog_pkg::*; #(
  parameter int NB_FULL  = 19,
  parameter int NB_SHIFT = 5,
  parameter int NB_OUT   = 16
) (
  input  logic [NB_FULL-1:0]  sum,
  input  logic [NB_SHIFT-1:0] shift,
  output logic [NB_OUT-1:0]   result,
  output logic                sat
);

  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (NB_OUT - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -OUT_MAX - 64'sd1;

  logic signed [63:0] sum_ext;
  logic signed [63:0] rounded;

  always_comb begin
    sum_ext = {{(64 - NB_FULL){sum[NB_FULL-1]}}, sum};
    rounded = round_half_up(sum_ext, {{(32 - NB_SHIFT){1'b0}}, shift});
    result  = rounded[NB_OUT-1:0];
    sat     = 1'b0;
    if (rounded > OUT_MAX) begin
      result = OUT_MAX[NB_OUT-1:0];
      sat    = 1'b1;
    end else if (rounded < OUT_MIN) begin
      result = OUT_MIN[NB_OUT-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_parallel_prog.sv
// Block FIR, PARALLELISM samples per beat, with a double-buffered coefficient
// bank and per-beat shift/round/saturate. Three register stages, latency 3.
module fir_parallel_prog import fir_prog_pkg::*; #(
  parameter int NB_IN       = 8,
  parameter int NB_COEFFS   = 8,
  parameter int N_COEFFS    = 8,
  parameter int PARALLELISM = 2,
  parameter int NB_OUT      = 16,
  localparam int NB_FULL    = full_width(NB_IN, NB_COEFFS, N_COEFFS),
  localparam int NB_SHIFT   = shift_width(NB_FULL),
  localparam int NB_ADDR    = $clog2(N_COEFFS)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [PARALLELISM*NB_IN-1:0]  i_data,
  input  logic [NB_SHIFT-1:0]           i_shift,
  input  logic                          i_coef_we,
  input  logic [NB_ADDR-1:0]            i_coef_addr,
  input  logic [NB_COEFFS-1:0]          i_coef_data,
  input  logic                          i_coef_commit,
  output logic                          o_valid,
  output logic [PARALLELISM*NB_OUT-1:0] o_data,
  output logic [PARALLELISM-1:0]        o_sat
);

  // Streaming: a beat is taken on every edge with i_valid=1 (no ready, no
  // back-pressure); o_valid marks each result beat for exactly one cycle and
  // o_data/o_sat hold between result beats.

  localparam int NB_PROD = NB_IN + NB_COEFFS;
  localparam int N_HIST  = N_COEFFS - 1;
  localparam int N_WIN   = N_HIST + PARALLELISM;

  logic signed [NB_IN-1:0]     hist     [N_HIST];
  logic signed [NB_IN-1:0]     win_next [N_WIN];
  logic signed [NB_IN-1:0]     s1_win   [N_WIN];
  logic                        s1_valid;
  logic [NB_SHIFT-1:0]         s1_shift;

  logic signed [NB_COEFFS-1:0] shadow      [N_COEFFS];
  logic signed [NB_COEFFS-1:0] shadow_next [N_COEFFS];
  logic signed [NB_COEFFS-1:0] active      [N_COEFFS];

  logic signed [NB_PROD-1:0]   s2_prod [PARALLELISM][N_COEFFS];
  logic                        s2_valid;
  logic [NB_SHIFT-1:0]         s2_shift;

  logic [NB_FULL-1:0]          lane_sum [PARALLELISM];
  logic [NB_OUT-1:0]           lane_res [PARALLELISM];
  logic [PARALLELISM-1:0]      lane_sat;

  // Window is oldest-first: stored history followed by this beat's lanes.
  always_comb begin
    for (int j = 0; j < N_HIST; j++) win_next[j] = hist[j];
    for (int l = 0; l < PARALLELISM; l++) win_next[N_HIST + l] = i_data[l*NB_IN +: NB_IN];
  end

  // Same-edge write is forwarded so a commit always sees the freshest shadow.
  always_comb begin
    for (int k = 0; k < N_COEFFS; k++) begin
      shadow_next[k] = shadow[k];
      if (i_coef_we && (i_coef_addr == NB_ADDR'(k))) shadow_next[k] = i_coef_data;
    end
  end

  // S1: history, window capture, coefficient banks.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int j = 0; j < N_HIST; j++) hist[j] <= '0;
      for (int j = 0; j < N_WIN; j++) s1_win[j] <= '0;
      for (int k = 0; k < N_COEFFS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      s1_valid <= 1'b0;
      s1_shift <= '0;
    end else begin
      for (int k = 0; k < N_COEFFS; k++) begin
        shadow[k] <= shadow_next[k];
        if (i_coef_commit) active[k] <= shadow_next[k];
      end
      s1_valid <= i_valid;
      if (i_valid) begin
        for (int j = 0; j < N_WIN; j++) s1_win[j] <= win_next[j];
        for (int j = 0; j < N_HIST; j++) hist[j] <= win_next[j + PARALLELISM];
        s1_shift <= i_shift;
      end
    end
  end

  // S2: only consumer of the active bank, so a commit splits beats cleanly.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int l = 0; l < PARALLELISM; l++)
        for (int k = 0; k < N_COEFFS; k++) s2_prod[l][k] <= '0;
      s2_valid <= 1'b0;
      s2_shift <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_shift <= s1_shift;
        for (int l = 0; l < PARALLELISM; l++)
          for (int k = 0; k < N_COEFFS; k++)
            s2_prod[l][k] <= NB_PROD'(s1_win[N_HIST + l - k]) * NB_PROD'(active[k]);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < PARALLELISM; l++) begin
      lane_sum[l] = '0;
      for (int k = 0; k < N_COEFFS; k++)
        lane_sum[l] = lane_sum[l] + {{(NB_FULL - NB_PROD){s2_prod[l][k][NB_PROD-1]}}, s2_prod[l][k]};
    end
  end

  for (genvar l = 0; l < PARALLELISM; l++) begin : g_lane
    fir_round_sat #(
      .NB_FULL  (NB_FULL),
      .NB_SHIFT (NB_SHIFT),
      .NB_OUT   (NB_OUT)
    ) u_round_sat (
      .sum    (lane_sum[l]),
      .shift  (s2_shift),
      .result (lane_res[l]),
      .sat    (lane_sat[l])
    );
  end

  // S3: output register, holds its value between valid beats.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        for (int l = 0; l < PARALLELISM; l++) o_data[l*NB_OUT +: NB_OUT] <= lane_res[l];
        o_sat <= lane_sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_parallel_prog.sv
// Bench for fir_parallel_prog: directed tables and sequences plus random
// traffic, all scored against a sample-history reference model.
module tb_fir_parallel_prog;

  localparam int P        = 2;
  localparam int N        = 8;
  localparam int NB_IN    = 8;
  localparam int NB_C     = 8;
  localparam int NB_OUT   = 16;
  localparam int NB_FULL  = NB_IN + NB_C + $clog2(N);
  localparam int NB_SHIFT = $clog2(NB_FULL);
  localparam int NB_ADDR  = $clog2(N);
  localparam int EW       = P*NB_OUT + P;

  logic                   i_clock = 1'b0;
  logic                   i_reset;
  logic                   i_valid;
  logic [P*NB_IN-1:0]     i_data;
  logic [NB_SHIFT-1:0]    i_shift;
  logic                   i_coef_we;
  logic [NB_ADDR-1:0]     i_coef_addr;
  logic [NB_C-1:0]        i_coef_data;
  logic                   i_coef_commit;
  logic                   o_valid;
  logic [P*NB_OUT-1:0]    o_data;
  logic [P-1:0]           o_sat;

  fir_parallel_prog #(
    .NB_IN(NB_IN), .NB_COEFFS(NB_C), .N_COEFFS(N), .PARALLELISM(P), .NB_OUT(NB_OUT)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .i_shift(i_shift), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data), .i_coef_commit(i_coef_commit),
    .o_valid(o_valid), .o_data(o_data), .o_sat(o_sat)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clock = ~i_clock;

  // ---------------- reference model + scoreboard ----------------
  int             hist_m[$];
  int             shadow_m[N];
  int             active_m[N];
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  obs_q[$];
  logic           vq[$];
  logic [EW-1:0]  last_exp;
  int             n_cmp  = 0;
  int             n_fail = 0;
  bit             mon_en = 1'b0;

  task automatic check_vec(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Round half up as floor(x/2^s + 0.5), then clip to the output range.
  function automatic void ref_round_sat(input longint sum, input int s, output longint r, output logic sat);
    real q;
    q = $floor(real'(sum) / (2.0 ** s) + 0.5);
    r = longint'(q);
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
  endfunction

  task automatic model_reset();
    hist_m.delete();
    for (int i = 0; i < N-1; i++) hist_m.push_back(0);
    for (int k = 0; k < N; k++) begin shadow_m[k] = 0; active_m[k] = 0; end
    exp_q.delete();
    vq.delete();
    for (int i = 0; i < 3; i++) vq.push_back(1'b0);
    last_exp = '0;
  endtask

  // Called at each rising edge with the values the DUT is sampling.
  task automatic model_edge();
    int            win[$];
    logic [EW-1:0] pkt;
    longint        acc, r;
    logic          s;
    int            base;
    if (i_reset) begin model_reset(); return; end
    if (i_coef_we) shadow_m[i_coef_addr] = int'($signed(i_coef_data));
    if (i_coef_commit) active_m = shadow_m;
    vq.push_back(i_valid);
    if (vq.size() > 3) void'(vq.pop_front());
    if (i_valid) begin
      win = hist_m;
      for (int l = 0; l < P; l++) win.push_back(int'($signed(i_data[l*NB_IN +: NB_IN])));
      pkt = '0;
      base = hist_m.size();
      for (int l = 0; l < P; l++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(active_m[k]) * longint'(win[base + l - k]);
        ref_round_sat(acc, int'(i_shift), r, s);
        pkt[l*NB_OUT +: NB_OUT] = r[NB_OUT-1:0];
        pkt[P*NB_OUT + l] = s;
      end
      exp_q.push_back(pkt);
      for (int i = 0; i < P; i++) void'(win.pop_front());
      hist_m = win;
    end
  endtask

  always @(negedge i_clock) begin : monitor
    logic          ev;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (mon_en) begin
      got = {o_sat, o_data};
      ev  = (vq.size() >= 3) ? vq[vq.size()-3] : 1'b0;
      check_int("o_valid", longint'(o_valid), longint'(ev));
      if (ev) begin
        if (exp_q.size() == 0) begin
          check_int("exp_queue_underflow", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check_vec("beat", got, e);
          last_exp = e;
        end
      end else begin
        check_vec("hold", got, last_exp);
      end
      if (o_valid) obs_q.push_back(got);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clock);
    assert (!(i_valid && (int'(i_shift) > NB_FULL-1))) else $error("illegal shift driven");
    model_edge();
    #1;
    i_valid       = 1'b0;
    i_coef_we     = 1'b0;
    i_coef_commit = 1'b0;
    i_reset       = 1'b0;
  endtask

  task automatic send(input int d0, input int d1, input int sh);
    i_valid = 1'b1;
    i_data  = {8'(d1), 8'(d0)};
    i_shift = NB_SHIFT'(sh);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_coef(input int a, input int v, input bit cm);
    i_coef_we     = 1'b1;
    i_coef_addr   = NB_ADDR'(a);
    i_coef_data   = 8'(v);
    i_coef_commit = cm;
    tick();
  endtask

  task automatic program_taps(input int h0, input int hr);
    for (int k = 0; k < N; k++) write_coef(k, (k == 0) ? h0 : hr, k == N-1);
  endtask

  task automatic program_ramp();
    for (int k = 0; k < N; k++) write_coef(k, k + 1, k == N-1);
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    tick();
  endtask

  function automatic int lane_val(input logic [EW-1:0] p, input int l);
    logic [NB_OUT-1:0] v;
    v = p[l*NB_OUT +: NB_OUT];
    return int'($signed(v));
  endfunction

  task automatic check_impulse(input string name);
    int exp_lane[10];
    exp_lane = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
    check_int({name, "_count"}, obs_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs_q.size()) begin
        check_int({name, "_lane0"}, lane_val(obs_q[i], 0), exp_lane[2*i]);
        check_int({name, "_lane1"}, lane_val(obs_q[i], 1), exp_lane[2*i+1]);
      end
  endtask

  task automatic impulse_stream();
    send(1, 0, 0);
    repeat (4) send(0, 0, 0);
    idle(4);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int         h0;
    int         hr;
    int         x;
    int         sh;
    int         e;
    logic [1:0] sat;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : main
    logic [EW-1:0] p;
    tbl[0]  = '{127, 127,  127,  0,  32767, 2'b11};
    tbl[1]  = '{127, 127, -128,  0, -32768, 2'b11};
    tbl[2]  = '{  3,   0,    1,  1,      2, 2'b00};
    tbl[3]  = '{ -3,   0,    1,  1,     -1, 2'b00};
    tbl[4]  = '{  5,   0,    1,  2,      1, 2'b00};
    tbl[5]  = '{  1,   1,    1,  0,      8, 2'b00};
    tbl[6]  = '{127, 127,  127,  3,  16129, 2'b00};
    tbl[7]  = '{127, 127,  127,  2,  32258, 2'b00};
    tbl[8]  = '{127, 127,  127,  1,  32767, 2'b11};
    tbl[9]  = '{127, 127, -128,  2, -32512, 2'b00};
    tbl[10] = '{127, 127, -128,  1, -32768, 2'b11};
    tbl[11] = '{127, 127, -128, 17,     -1, 2'b00};
    tbl[12] = '{127, 127,  127, 17,      1, 2'b00};
    tbl[13] = '{-128, -128, -128, 0,  32767, 2'b11};
    tbl[14] = '{-128, -128, -128, 2,  32767, 2'b11};
    tbl[15] = '{-128, -128, -128, 3,  16384, 2'b00};
    tbl[16] = '{  2,   0,   -1,  2,      0, 2'b00};

    i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_shift = '0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0; i_coef_commit = 1'b0;
    reset_dut();
    mon_en = 1'b1;
    idle(2);

    // impulse response, contiguous beats
    program_ramp();
    obs_q.delete();
    impulse_stream();
    check_impulse("impulse");

    // same impulse with gaps between beats
    obs_q.delete();
    send(1, 0, 0); idle(2);
    send(0, 0, 0); idle(1);
    send(0, 0, 0); idle(2);
    send(0, 0, 0);
    send(0, 0, 0);
    idle(4);
    check_impulse("gapped");

    // round / saturate table, steady-state sum = x*(h0 + 7*hr)
    for (int i = 0; i < 17; i++) begin
      program_taps(tbl[i].h0, tbl[i].hr);
      obs_q.delete();
      repeat (5) send(tbl[i].x, tbl[i].x, tbl[i].sh);
      idle(4);
      check_int($sformatf("row%0d_count", i), obs_q.size(), 5);
      if (obs_q.size() > 0) begin
        p = obs_q[obs_q.size()-1];
        check_int($sformatf("row%0d_lane0", i), lane_val(p, 0), tbl[i].e);
        check_int($sformatf("row%0d_lane1", i), lane_val(p, 1), tbl[i].e);
        check_int($sformatf("row%0d_sat", i), p[P*NB_OUT +: P], tbl[i].sat);
      end
    end

    // bank swap mid-stream, tap 0 written on the commit edge
    program_taps(1, 1);
    repeat (5) send(1, 1, 0);
    idle(4);
    obs_q.delete();
    for (int k = 1; k < N; k++) begin
      i_coef_we = 1'b1; i_coef_addr = NB_ADDR'(k); i_coef_data = 8'd2;
      send(1, 1, 0);
    end
    i_coef_we = 1'b1; i_coef_addr = '0; i_coef_data = 8'd2; i_coef_commit = 1'b1;
    send(1, 1, 0);
    repeat (3) send(1, 1, 0);
    idle(4);
    check_int("swap_count", obs_q.size(), 11);
    for (int i = 0; i < 11; i++)
      if (i < obs_q.size()) begin
        check_int("swap_lane0", lane_val(obs_q[i], 0), (i < 7) ? 8 : 16);
        check_int("swap_lane1", lane_val(obs_q[i], 1), (i < 7) ? 8 : 16);
      end

    // reset with two beats in flight, then banks must read as zero
    send(3, 3, 0);
    send(5, 5, 0);
    obs_q.delete();
    reset_dut();
    impulse_stream();
    check_int("post_reset_count", obs_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs_q.size()) check_vec("post_reset_zero", obs_q[i], '0);
    program_ramp();
    obs_q.delete();
    impulse_stream();
    check_impulse("reprogrammed");

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_data  = 16'($urandom);
      i_shift = NB_SHIFT'($urandom_range(0, NB_FULL-1));
      if ($urandom_range(0, 9) == 0) begin
        i_coef_we   = 1'b1;
        i_coef_addr = NB_ADDR'($urandom_range(0, N-1));
        i_coef_data = 8'($urandom);
      end
      i_coef_commit = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(5);
    check_int("exp_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_parallel_prog.md
Name: fir_parallel_prog

Overview:
Next-generation parallel (block) FIR: PARALLELISM samples per clock, N_COEFFS taps, with valid-qualified streaming and run-time programmable coefficients. Coefficients are written to a double-buffered bank and swapped atomically. The block also provides a per-beat selectable output shift with round-half-up and saturation to NB_OUT. It sits in the datapath where the fixed-coefficient parallel FIR was used, feeding narrower downstream stages.

Parameters:
NB_IN, 8, signed input sample width
NB_COEFFS, 8, signed coefficient width
N_COEFFS, 8, number of taps (>=2)
PARALLELISM, 2, samples per beat (1..N_COEFFS)
NB_OUT, 16, signed output width after shift/round/saturate
NB_FULL, NB_IN+NB_COEFFS+$clog2(N_COEFFS), derived full-precision accumulator width (localparam)
NB_SHIFT, $clog2(NB_FULL), derived shift-control width (localparam)

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  input beat valid
i_data  in  signed [NB_IN-1:0] x [PARALLELISM]  lane 0 = oldest sample of beat
i_shift  in  [NB_SHIFT-1:0]  right-shift applied to full sum, sampled with i_valid
i_coef_we  in  1  write enable into shadow bank
i_coef_addr  in  [$clog2(N_COEFFS)-1:0]  tap index
i_coef_data  in  signed [NB_COEFFS-1:0]  tap value
i_coef_commit  in  1  copy shadow bank to active bank
o_valid  out  1  output beat valid
o_data  out  signed [NB_OUT-1:0] x [PARALLELISM]  filtered lanes, lane 0 = oldest
o_sat  out  [PARALLELISM-1:0]  per-lane saturation flag for current output beat

Behaviour:
- Reset (edge with i_reset=1): delay line, shadow and active banks cleared to 0; pipeline valids 0; o_valid=0, o_data=0, o_sat=0. Reset overrides all other inputs on that edge; in-flight beats are discarded.
- Function: for global sample index n = beat*PARALLELISM+lane, y[n] = sum_{k=0..N_COEFFS-1} h[k]*x[n-k]; history before the first post-reset beat is 0.
- Delay line (N_COEFFS-1 samples) advances only on edges with i_valid=1; with i_valid=0, history is held (gaps transparent).
- Pipeline, 3 register stages: S1 input/history/shift register; S2 PARALLELISM*N_COEFFS products registered at full width; S3 adder tree + round + saturate into output register. A beat sampled at edge k yields o_valid=1 in the cycle after edge k+2, i.e. latency 3. Throughput 1 beat/clock, no back-pressure.
- o_data/o_sat hold their last values while o_valid=0; they are not zeroed.
- Arithmetic: full sum in NB_FULL bits, no overflow possible. If s=i_shift>0: r=(sum + 2^(s-1)) >>> s (arithmetic, round half toward +inf); if s=0: r=sum. Saturate r to [-2^(NB_OUT-1), 2^(NB_OUT-1)-1]; o_sat[l]=1 iff lane l clipped. i_shift values >NB_FULL-1 are illegal (bench asserts).
- Coefficient write: on edge with i_coef_we=1, shadow[i_coef_addr] <= i_coef_data. Active bank is untouched.
- Commit: on edge with i_coef_commit=1, active <= shadow. Same-edge write+commit: the written value is included (forwarded). Beats sampled at edge >= commit edge use the new bank; beats sampled earlier use the old bank (S2 is the sole consumer of the active bank). No output glitch or mixed-bank beat.
- Commit and i_valid are independent; commit during a gap is legal.

Decomposition:
- Package fir_prog_pkg: round/saturate function prototype and width helper functions (full-width and shift-width computation); no instance-specific typedefs.
- Sub-module fir_round_sat: parameters NB_FULL, NB_SHIFT, NB_OUT; inputs sum and shift; outputs result and sat flag. Purely combinational, instantiated per lane inside S3.

Test Plan:
- Impulse, P=2, N=8, h=1..8, shift 0: beat0=(1,0), then zeros -> outputs (1,2),(3,4),(5,6),(7,8),(0,0), first one 3 cycles after input.
- Valid gaps: same impulse with i_valid toggled 1,0,0,1,... -> identical output sequence; o_valid pattern matches input pattern delayed by 3.
- Saturation: h all 127, x all 127, shift 0, NB_OUT=16 -> sum 129032 -> o_data=32767, o_sat=11; x all -128 -> -130048 -> -32768, o_sat=11.
- Rounding: sums 3 and -3 with shift 1 -> 2 and -1; sum 5 with shift 2 -> 1, o_sat=0.
- Bank swap mid-stream: constant x=1, h=1 (all taps) then write h=2 to all taps and commit at edge k -> beats sampled before k give 8, beats from k give 16, with no intermediate values; same-edge write+commit on tap 0 is included.
- Reset mid-stream: assert i_reset with 2 beats in flight -> o_valid=0 next cycle, no stale beats emerge, and the post-reset impulse reproduces scenario 1 with h=0 (all-zero output) until the bank is reprogrammed.
